// File: rtl/sha512_msg_padder.sv
// sha512_msg_padder
//   Upstream stage of the SHA-512 round engine. Collects a message arriving
//   as 64-bit big-endian words into 1024-bit blocks and applies SHA-512
//   padding: a 0x80 marker byte, zero fill, then the 128-bit message bit
//   length in words 14-15 of the final block. Each block is presented with
//   first/last flags and the message mode over a valid/ready handshake.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   msg_valid/msg_ready  word handshake into the padder
//   msg_data             message word, byte 0 in bits [63:56]
//   msg_last             final word of the message
//   msg_bytes            valid bytes in the word (0..8, 8 unless last)
//   msg_mode             mode, sampled with the first word of a message
//   blk_valid/blk_ready  block handshake towards the round engine
//   blk_data             block, word 0 in bits [1023:960]
//   blk_init             first block of a message
//   blk_last             final block of a message
//   blk_mode             mode latched from the first word
module sha512_msg_padder #(
  parameter int LEN_W = 128,
  parameter int WORDS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  msg_valid,
  output logic                  msg_ready,
  input  logic [63:0]           msg_data,
  input  logic                  msg_last,
  input  logic [3:0]            msg_bytes,
  input  logic [31:0]           msg_mode,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic [64*WORDS-1:0]   blk_data,
  output logic                  blk_init,
  output logic                  blk_last,
  output logic [31:0]           blk_mode
);

  localparam int CNT_W = LEN_W - 3;
  localparam int IDX_W = $clog2(WORDS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [IDX_W-1:0] LEN_IDX  = IDX_W'(WORDS - 3);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-2:0] LO_ONE   = (IDX_W-1)'(1);
  localparam logic [63:0]      ONES     = {64{1'b1}};
  localparam logic [63:0]      MARK     = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {IDLE, FILL, PAD, XPAD, EMIT} state_e;

  state_e                   state_q, state_d;
  state_e                   cont_q, cont_d;
  logic [IDX_W-1:0]         widx_q, widx_d;
  logic [CNT_W-1:0]         byte_cnt_q, byte_cnt_d;
  logic [WORDS-1:0][63:0]   buf_q, buf_d;
  logic                     pend_q, pend_d;
  logic                     fits_q, fits_d;
  logic                     first_q, first_d;
  logic                     blk_valid_q, blk_valid_d;
  logic                     blk_init_q, blk_init_d;
  logic                     blk_last_q, blk_last_d;
  logic [31:0]              blk_mode_q, blk_mode_d;
  logic                     msg_ready_q, msg_ready_d;

  logic                     accept;
  logic [3:0]               eff_bytes;
  logic                     full_word;
  logic [63:0]              word_v;
  logic [IDX_W-1:0]         mark_idx;
  logic [IDX_W-2:0]         widx_lo;
  logic [127:0]             bit_len;

  assign widx_lo = widx_q[IDX_W-2:0];
  assign bit_len = 128'({byte_cnt_q, 3'b000});

  // Next-state logic. fits_q records, at the last word, whether the marker
  // byte landed early enough (word <= 13) for the length to share its block;
  // otherwise an extra all-padding block is produced through XPAD.
  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    widx_d      = widx_q;
    byte_cnt_d  = byte_cnt_q;
    buf_d       = buf_q;
    pend_d      = pend_q;
    fits_d      = fits_q;
    first_d     = first_q;
    blk_init_d  = blk_init_q;
    blk_last_d  = blk_last_q;
    blk_mode_d  = blk_mode_q;
    word_v      = '0;
    mark_idx    = '0;
    accept      = msg_valid && msg_ready_q;
    eff_bytes   = (msg_bytes > 4'd8) ? 4'd8 : msg_bytes;
    full_word   = eff_bytes[3];

    case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          if (state_q == IDLE) begin
            blk_mode_d = msg_mode;
            first_d    = 1'b1;
          end
          // Keep only the leading eff_bytes bytes; a short last word also
          // carries the marker right after its final data byte.
          word_v = full_word ? msg_data
                             : (msg_data & ~(ONES >> {eff_bytes[2:0], 3'b000}));
          if (msg_last && !full_word) begin
            word_v = word_v | (MARK >> {eff_bytes[2:0], 3'b000});
          end
          buf_d[widx_lo] = word_v;
          byte_cnt_d     = byte_cnt_q + CNT_W'(eff_bytes);
          widx_d         = widx_q + IDX_ONE;

          if (msg_last) begin
            mark_idx = widx_q + {{(IDX_W-1){1'b0}}, full_word};
            if (full_word) begin
              // A full final word pushes the marker into the next word, or
              // into the next block when this was word 15.
              if (widx_q == LAST_IDX) begin
                pend_d = 1'b1;
              end else begin
                buf_d[widx_lo + LO_ONE] = MARK;
              end
            end
            fits_d  = (mark_idx <= LEN_IDX);
            state_d = PAD;
          end else if (widx_q == LAST_IDX) begin
            state_d    = EMIT;
            cont_d     = FILL;
            blk_init_d = first_d;
            blk_last_d = 1'b0;
          end else begin
            state_d = FILL;
          end
        end
      end

      PAD: begin
        state_d    = EMIT;
        blk_init_d = first_q;
        if (fits_q) begin
          buf_d[WORDS-2] = bit_len[127:64];
          buf_d[WORDS-1] = bit_len[63:0];
          blk_last_d     = 1'b1;
          cont_d         = IDLE;
        end else begin
          blk_last_d = 1'b0;
          cont_d     = XPAD;
        end
      end

      XPAD: begin
        if (pend_q) begin
          buf_d[0] = MARK;
          pend_d   = 1'b0;
        end
        buf_d[WORDS-2] = bit_len[127:64];
        buf_d[WORDS-1] = bit_len[63:0];
        blk_init_d     = first_q;
        blk_last_d     = 1'b1;
        cont_d         = IDLE;
        state_d        = EMIT;
      end

      EMIT: begin
        if (blk_valid_q && blk_ready) begin
          buf_d      = '0;
          widx_d     = '0;
          first_d    = 1'b0;
          blk_init_d = 1'b0;
          blk_last_d = 1'b0;
          state_d    = cont_q;
          if (cont_q == IDLE) begin
            byte_cnt_d = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    blk_valid_d = (state_d == EMIT);
    msg_ready_d = (state_d == IDLE) || (state_d == FILL);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cont_q      <= IDLE;
      widx_q      <= '0;
      byte_cnt_q  <= '0;
      buf_q       <= '0;
      pend_q      <= 1'b0;
      fits_q      <= 1'b0;
      first_q     <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_init_q  <= 1'b0;
      blk_last_q  <= 1'b0;
      blk_mode_q  <= '0;
      msg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cont_q      <= cont_d;
      widx_q      <= widx_d;
      byte_cnt_q  <= byte_cnt_d;
      buf_q       <= buf_d;
      pend_q      <= pend_d;
      fits_q      <= fits_d;
      first_q     <= first_d;
      blk_valid_q <= blk_valid_d;
      blk_init_q  <= blk_init_d;
      blk_last_q  <= blk_last_d;
      blk_mode_q  <= blk_mode_d;
      msg_ready_q <= msg_ready_d;
    end
  end

  // Word 0 of the buffer occupies the most significant 64 bits of the block.
  always_comb begin
    blk_data = '0;
    for (int i = 0; i < WORDS; i++) begin
      blk_data[64*(WORDS-1-i) +: 64] = buf_q[i];
    end
  end

  assign blk_valid = blk_valid_q;
  assign blk_init  = blk_init_q;
  assign blk_last  = blk_last_q;
  assign blk_mode  = blk_mode_q;
  assign msg_ready = msg_ready_q;

endmodule

// File: tb/tb_sha512_msg_padder.sv
// tb_sha512_msg_padder
//   Directed bench for sha512_msg_padder. Expected blocks are queued when a
//   message is issued; a monitor pops and compares on every block handshake.
module tb_sha512_msg_padder;

  logic          clk = 1'b0;
  logic          rst;
  logic          msg_valid;
  logic          msg_ready;
  logic [63:0]   msg_data;
  logic          msg_last;
  logic [3:0]    msg_bytes;
  logic [31:0]   msg_mode;
  logic          blk_valid;
  logic          blk_ready;
  logic [1023:0] blk_data;
  logic          blk_init;
  logic          blk_last;
  logic [31:0]   blk_mode;

  typedef struct packed {
    logic [1023:0] data;
    logic          init;
    logic          last;
    logic [31:0]   mode;
  } blk_t;

  localparam logic [63:0] MARK = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ABC  = 64'h6162_6300_0000_0000;

  blk_t expQ[$];
  int   vecCount  = 0;
  int   missCount = 0;

  sha512_msg_padder dut (
    .clk       (clk),
    .rst       (rst),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_data  (msg_data),
    .msg_last  (msg_last),
    .msg_bytes (msg_bytes),
    .msg_mode  (msg_mode),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_init  (blk_init),
    .blk_last  (blk_last),
    .blk_mode  (blk_mode)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'(i * 3 + 1)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkBlock(input blk_t e);
    logic [63:0] aw;
    logic [63:0] ew;
    int          bad;
    bad = -1;
    aw  = '0;
    ew  = '0;
    for (int i = 0; i < 16; i++) begin
      if (bad < 0 && blk_data[1023-64*i -: 64] !== e.data[1023-64*i -: 64]) begin
        bad = i;
        aw  = blk_data[1023-64*i -: 64];
        ew  = e.data[1023-64*i -: 64];
      end
    end
    vecCount++;
    if (bad >= 0) begin
      missCount++;
      $display("[TB] FAIL blk_data word %0d: got %h expected %h", bad, aw, ew);
    end
    checkOutput("blk_init", 64'(blk_init), 64'(e.init));
    checkOutput("blk_last", 64'(blk_last), 64'(e.last));
    checkOutput("blk_mode", 64'(blk_mode), 64'(e.mode));
  endtask

  // Monitor: every accepted block is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && blk_valid && blk_ready) begin
      if (expQ.size() == 0) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL unexpected_block: got init=%0b last=%0b expected no block",
                 blk_init, blk_last);
      end else begin
        checkBlock(expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [63:0] d, input logic last,
                               input logic [3:0] nb, input logic [31:0] mode);
    bit done;
    done      = 1'b0;
    msg_data  = d;
    msg_last  = last;
    msg_bytes = nb;
    msg_mode  = mode;
    msg_valid = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (msg_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    if (!done) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL accept_timeout: got msg_ready=0 expected 1");
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !blk_valid) done = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!done) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL drain_timeout: got %0d pending blocks expected 0", expQ.size());
    end
  endtask

  function automatic blk_t abcBlock(input logic [31:0] mode);
    logic [0:15][63:0] ew;
    blk_t b;
    ew     = '0;
    ew[0]  = 64'h6162_6380_0000_0000;
    ew[15] = 64'h18;
    b.data = ew;
    b.init = 1'b1;
    b.last = 1'b1;
    b.mode = mode;
    return b;
  endfunction

  // Directed stimulus sequence.
  initial begin
    logic [0:15][63:0] ew;
    blk_t              b;
    bit                seen;

    rst       = 1'b1;
    msg_valid = 1'b0;
    msg_data  = '0;
    msg_last  = 1'b0;
    msg_bytes = '0;
    msg_mode  = '0;
    blk_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_blk_valid", 64'(blk_valid), 64'd0);
    checkOutput("rst_msg_ready", 64'(msg_ready), 64'd0);
    checkOutput("rst_blk_init",  64'(blk_init),  64'd0);
    checkOutput("rst_blk_last",  64'(blk_last),  64'd0);
    checkOutput("rst_blk_mode",  64'(blk_mode),  64'd0);
    checkOutput("rst_blk_data",  64'(|blk_data), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // "abc": one block, valid two cycles after the last word.
    $display("[TB] abc message");
    expQ.push_back(abcBlock(32'd512));
    applyStimulus(ABC, 1'b1, 4'd3, 32'd512);
    @(negedge clk);
    checkOutput("lat_pad_valid", 64'(blk_valid), 64'd0);
    @(negedge clk);
    checkOutput("lat_emit_valid", 64'(blk_valid), 64'd1);
    drain();

    // Empty message.
    $display("[TB] empty message");
    ew     = '0;
    ew[0]  = MARK;
    b.data = ew; b.init = 1'b1; b.last = 1'b1; b.mode = 32'd224;
    expQ.push_back(b);
    applyStimulus(64'h0, 1'b1, 4'd0, 32'd224);
    drain();

    // 112 bytes: marker in word 14, length spills into a second block.
    $display("[TB] 112-byte message");
    ew = '0;
    for (int i = 0; i < 14; i++) ew[i] = pat(i);
    ew[14] = MARK;
    b.data = ew; b.init = 1'b1; b.last = 1'b0; b.mode = 32'd512;
    expQ.push_back(b);
    ew     = '0;
    ew[15] = 64'h380;
    b.data = ew; b.init = 1'b0; b.last = 1'b1; b.mode = 32'd512;
    expQ.push_back(b);
    for (int i = 0; i < 14; i++) applyStimulus(pat(i), i == 13, 4'd8, 32'd512);
    drain();

    // 128 bytes: marker pending into the second block.
    $display("[TB] 128-byte message");
    ew = '0;
    for (int i = 0; i < 16; i++) ew[i] = pat(i + 20);
    b.data = ew; b.init = 1'b1; b.last = 1'b0; b.mode = 32'h1234;
    expQ.push_back(b);
    ew     = '0;
    ew[0]  = MARK;
    ew[15] = 64'h400;
    b.data = ew; b.init = 1'b0; b.last = 1'b1; b.mode = 32'h1234;
    expQ.push_back(b);
    for (int i = 0; i < 16; i++) applyStimulus(pat(i + 20), i == 15, 4'd8, 32'h1234);
    drain();

    // Backpressure: five stalled EMIT cycles, handshake on the sixth.
    $display("[TB] backpressure");
    blk_ready = 1'b0;
    b = abcBlock(32'd256);
    expQ.push_back(b);
    applyStimulus(ABC, 1'b1, 4'd3, 32'd256);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (blk_valid) seen = 1'b1;
    end
    checkOutput("bp_valid_seen", 64'(seen), 64'd1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_valid_held", 64'(blk_valid), 64'd1);
      checkOutput("bp_data_stable", 64'(|(blk_data ^ b.data)), 64'd0);
      checkOutput("bp_msg_ready", 64'(msg_ready), 64'd0);
      @(posedge clk);
      #1;
      if (k == 4) blk_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_valid_drop", 64'(blk_valid), 64'd0);
    drain();

    // Reset after five words, then a clean "abc".
    $display("[TB] reset mid-message");
    for (int i = 0; i < 5; i++) applyStimulus(pat(i + 50), 1'b0, 4'd8, 32'd384);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_valid", 64'(blk_valid), 64'd0);
    checkOutput("mid_rst_ready", 64'(msg_ready), 64'd0);
    checkOutput("mid_rst_mode",  64'(blk_mode),  64'd0);
    checkOutput("mid_rst_data",  64'(|blk_data), 64'd0);
    checkOutput("mid_rst_init",  64'(blk_init),  64'd0);
    checkOutput("mid_rst_last",  64'(blk_last),  64'd0);
    expQ.push_back(abcBlock(32'd512));
    applyStimulus(ABC, 1'b1, 4'd3, 32'd512);
    drain();

    checkOutput("leftover_blocks", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
